// File: rtl/fifo_pkg.sv
// Shared constants for the FIFO read-side streaming logic.
// Holds the controller state encoding and the output buffer depth.
// Imported by fifo_rd_stream and fifo_skid_buf.
package fifo_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;

  localparam int RD_BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// 2-entry circular buffer with push/pop and occupancy count.
// Latency: a pushed word is visible on data the cycle after push.
// Backpressure: caller must not push when full; pop is ignored when empty.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [width-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [width-1:0] data,
  output logic [1:0]       count
);

  logic [width-1:0] mem [RD_BUF_DEPTH];
  logic             head;
  logic             tail;
  logic             do_pop;

  assign do_pop = pop & valid;
  assign valid  = (count != 2'd0);
  // Output comes straight from storage so it never depends on the FIFO read path.
  assign data   = mem[head];

  // Storage, pointers and count; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      head  <= 1'b0;
      tail  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= ~tail;
      end
      if (do_pop) begin
        head <= ~head;
      end
      count <= count + 2'(push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops a synchronous FIFO and presents its words as a valid/ready stream.
// Latency: first word on m_data 2 cycles after its pop; 1 word/cycle sustained.
// Backpressure: pops only when the 2-entry buffer has room for all words in flight.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int fifo_data_width = 4,
  parameter int pop_gap         = 0,
  parameter int cnt_width       = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       fifo_rd_empty,
  output logic                       fifo_rd_vld,
  input  logic [fifo_data_width-1:0] fifo_rd_data,
  output logic                       m_valid,
  output logic [fifo_data_width-1:0] m_data,
  input  logic                       m_ready,
  output logic                       idle,
  output logic [cnt_width-1:0]       pop_cnt
);

  state_t     state;
  state_t     state_nxt;
  logic       inflight;
  logic       gap;
  logic       deq;
  logic       pop;
  logic [1:0] buf_count;
  logic [2:0] occ;

  assign deq = m_valid & m_ready;

  // Words held or arriving next cycle, net of the one leaving now.
  assign occ = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, deq};

  // Combinational through m_ready so a full-rate stream keeps one pop per cycle;
  // rst_n gating keeps the strobe quiet while reset is held.
  assign pop = rst_n & en & ~fifo_rd_empty & ~gap & (state != S_DRAIN) & (occ < 3'd2);
  assign fifo_rd_vld = pop;

  // Pop bookkeeping: read data lands one cycle after the pop; optional idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      gap      <= 1'b0;
      pop_cnt  <= '0;
    end else begin
      inflight <= pop;
      gap      <= pop & (pop_gap != 0);
      if (pop) begin
        pop_cnt <= pop_cnt + {{(cnt_width-1){1'b0}}, 1'b1};
      end
    end
  end

  fifo_skid_buf #(
    .width(fifo_data_width)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .count    (buf_count)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: once draining, en is ignored until the pipeline is empty.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (en) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!en) state_nxt = (inflight || buf_count != 2'd0) ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (!inflight && buf_count == 2'd0) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs: idle only when nothing is in flight or buffered.
  always_comb begin
    idle = 1'b0;
    if (state == S_IDLE && !inflight && buf_count == 2'd0) idle = 1'b1;
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: two instances (no gap with 4-bit counter, gap with 16-bit counter).
// Each has a FIFO model; words loaded are pushed to a scoreboard queue,
// and a monitor compares every accepted output word against it.
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, m_ready, en_g, m_ready_g;
  int   n_chk  = 0;
  int   n_pass = 0;

  // FIFO model A (no-gap instance)
  logic [W-1:0] mem_a [64];
  int           wr_a = 0;
  int           rd_a = 0;
  logic         flush_a = 1'b0;
  logic [W-1:0] rdat_a = '0;
  logic         empty_a;
  logic         vld_a, mv_a, idle_a;
  logic [W-1:0] md_a;
  logic [3:0]   cnt_a;
  assign empty_a = (wr_a == rd_a);

  // FIFO model B (gap instance)
  logic [W-1:0] mem_b [64];
  int           wr_b = 0;
  int           rd_b = 0;
  logic [W-1:0] rdat_b = '0;
  logic         empty_b;
  logic         vld_b, mv_b, idle_b;
  logic [W-1:0] md_b;
  logic [15:0]  cnt_b;
  assign empty_b = (wr_b == rd_b);

  logic [W-1:0] exp_a [$];
  logic [W-1:0] exp_b [$];

  always @(posedge clk) begin
    if (flush_a) rd_a <= wr_a;
    else if (vld_a) begin
      rdat_a <= mem_a[rd_a[5:0]];
      rd_a   <= rd_a + 1;
    end
  end

  always @(posedge clk) begin
    if (vld_b) begin
      rdat_b <= mem_b[rd_b[5:0]];
      rd_b   <= rd_b + 1;
    end
  end

  fifo_rd_stream #(.fifo_data_width(W), .pop_gap(0), .cnt_width(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .fifo_rd_empty(empty_a), .fifo_rd_vld(vld_a),
    .fifo_rd_data(rdat_a), .m_valid(mv_a), .m_data(md_a), .m_ready(m_ready),
    .idle(idle_a), .pop_cnt(cnt_a)
  );

  fifo_rd_stream #(.fifo_data_width(W), .pop_gap(1), .cnt_width(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_g), .fifo_rd_empty(empty_b), .fifo_rd_vld(vld_b),
    .fifo_rd_data(rdat_b), .m_valid(mv_b), .m_data(md_b), .m_ready(m_ready_g),
    .idle(idle_b), .pop_cnt(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitors: compare each accepted word; check buffer never captures when full.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mv_a && m_ready) begin
        if (exp_a.size() == 0) chk("unexpected_word_a", 32'(md_a), 32'hFFFF_FFFF);
        else chk("data_a", 32'(md_a), 32'(exp_a.pop_front()));
      end
      if (dut_a.inflight) chk("capture_room_a", 32'(dut_a.buf_count != 2'd2), 32'd1);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (mv_b && m_ready_g) begin
        if (exp_b.size() == 0) chk("unexpected_word_b", 32'(md_b), 32'hFFFF_FFFF);
        else chk("data_b", 32'(md_b), 32'(exp_b.pop_front()));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load_a(input logic [W-1:0] v);
    mem_a[wr_a[5:0]] = v;
    wr_a++;
    exp_a.push_back(v);
  endtask

  task automatic load_b(input logic [W-1:0] v);
    mem_b[wr_b[5:0]] = v;
    wr_b++;
    exp_b.push_back(v);
  endtask

  task automatic wait_drain_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_a.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_a_left", 32'(exp_a.size()), 32'd0);
  endtask

  task automatic wait_drain_b(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_b.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_b_left", 32'(exp_b.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; en_g = 1'b0; m_ready_g = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_m_valid", 32'(mv_a), 32'd0);
    chk("rst_m_data", 32'(md_a), 32'd0);
    chk("rst_idle", 32'(idle_a), 32'd1);
    chk("rst_pop_cnt", 32'(cnt_a), 32'd0);
    chk("rst_state", 32'(dut_a.state), 32'(S_IDLE));

    // Preloaded 1..4 at full rate
    cyc();
    for (int i = 1; i <= 4; i++) load_a(W'(i));
    en = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk("t1_pop", 32'(vld_a), 32'(k < 4));
      chk("t1_m_valid", 32'(mv_a), 32'(k >= 2 && k <= 5));
    end
    cyc(); en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t1_pop_cnt", 32'(cnt_a), 32'd4);
    chk("t1_idle", 32'(idle_a), 32'd1);

    // Stall: only two pops may happen while m_ready is low
    cyc(); m_ready = 1'b0;
    for (int i = 0; i < 8; i++) load_a(W'(5 + i));
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t2_pop", 32'(vld_a), 32'(k < 2));
    end
    chk("t2_hold_valid", 32'(mv_a), 32'd1);
    chk("t2_hold_data", 32'(md_a), 32'h5);
    chk("t2_pop_cnt", 32'(cnt_a), 32'd6);
    cyc(); m_ready = 1'b1;
    wait_drain_a(40);
    cyc(); en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t2_pop_cnt_end", 32'(cnt_a), 32'd12);

    // Gap mode: pops alternate with idle cycles
    cyc();
    load_b(4'h3); load_b(4'h7); load_b(4'h9); load_b(4'hE);
    en_g = 1'b1; m_ready_g = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t3_gap_pop", 32'(vld_b), 32'(k < 7 && (k % 2) == 0));
    end
    wait_drain_b(20);
    cyc(); en_g = 1'b0;
    @(negedge clk);
    chk("t3_pop_cnt", 32'(cnt_b), 32'd4);

    // Drain: en drops with count=1, rises again inside S_DRAIN
    cyc(); m_ready = 1'b0;
    load_a(4'hA); load_a(4'hB); load_a(4'hC);
    en = 1'b1;
    @(negedge clk); chk("t4_pop0", 32'(vld_a), 32'd1);
    cyc();
    @(negedge clk); chk("t4_pop1", 32'(vld_a), 32'd1);
    cyc(); en = 1'b0;
    @(negedge clk); chk("t4_no_pop_en0", 32'(vld_a), 32'd0);
    cyc(); en = 1'b1;
    @(negedge clk);
    chk("t4_state_drain", 32'(dut_a.state), 32'(S_DRAIN));
    chk("t4_no_pop_drain", 32'(vld_a), 32'd0);
    cyc(); m_ready = 1'b1;
    @(negedge clk); chk("t4_no_pop_c4", 32'(vld_a), 32'd0);
    @(negedge clk); chk("t4_no_pop_c5", 32'(vld_a), 32'd0);
    @(negedge clk); chk("t4_state_c6", 32'(dut_a.state), 32'(S_DRAIN));
    @(negedge clk);
    chk("t4_state_idle", 32'(dut_a.state), 32'(S_IDLE));
    chk("t4_idle", 32'(idle_a), 32'd1);
    chk("t4_pop_resume", 32'(vld_a), 32'd1);
    @(negedge clk); chk("t4_state_run", 32'(dut_a.state), 32'(S_RUN));
    wait_drain_a(20);
    cyc(); en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t4_idle_end", 32'(idle_a), 32'd1);
    chk("t4_pop_cnt", 32'(cnt_a), 32'd15);

    // Asynchronous reset with a full buffer
    cyc(); m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load_a(W'(i));
    en = 1'b1;
    cyc(); cyc(); cyc();
    chk("t5_pre_full", 32'(mv_a), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(mv_a), 32'd0);
    chk("t5_rst_cnt", 32'(cnt_a), 32'd0);
    chk("t5_rst_idle", 32'(idle_a), 32'd1);
    chk("t5_rst_no_pop", 32'(vld_a), 32'd0);
    exp_a.delete();
    flush_a = 1'b1;
    @(negedge clk); chk("t5_rst_no_pop_hold", 32'(vld_a), 32'd0);
    cyc();
    flush_a = 1'b0; en = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("t5_after_rst_valid", 32'(mv_a), 32'd0);

    // Counter wrap: 17 pops on a 4-bit counter
    cyc(); m_ready = 1'b1;
    for (int i = 0; i < 17; i++) load_a(W'(i));
    en = 1'b1;
    wait_drain_a(100);
    cyc(); en = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("t6_pop_cnt_wrap", 32'(cnt_a), 32'd1);
    chk("t6_idle", 32'(idle_a), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
